note_scheduler: RTL and testbench
=================================

NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter ADDR_W, default 10: song ROM address width.
REQ-002 Parameter DUR_W, default 6: note duration width, in beats.
REQ-003 Parameter PITCH_W, default 24: tone-generator step-size width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 play  in  1  level; 1 = run/continue, 0 = pause.
REQ-008 rewind  in  1  single-cycle pulse; return to song start.
REQ-009 beat  in  1  single-cycle tick from beat_generator.
REQ-010 rom_addr  out  ADDR_W  song ROM address; synchronous ROM, 1-cycle read latency.
REQ-011 rom_data  in  DUR_W+PITCH_W  entry {duration, pitch}; duration 0 = end-of-song marker.
REQ-012 note_pitch  out  PITCH_W  registered pitch to tone generator.
REQ-013 note_duration  out  DUR_W  registered duration to dynamics block.
REQ-014 note_start  out  1  one-cycle pulse; dynamics restarts envelope.
REQ-015 done_with_note  out  1  one-cycle pulse at note end.
REQ-016 tone_en  out  1  tone generator enable.
REQ-017 song_done  out  1  level; high in END.

Function
REQ-018 The block SHALL use FSM states IDLE, FETCH, LOAD, PLAY, GAP, END.
REQ-019 IDLE: play=1 -> FETCH; rom_addr holds current address throughout FETCH.
REQ-020 FETCH -> LOAD unconditionally (ROM latency cycle).
REQ-021 LOAD with rom_data duration=0 -> END: song_done=1, tone_en=0, no note_start.
REQ-022 LOAD with duration!=0 -> PLAY: latch pitch/duration, load beat counter with duration, note_start=1 for the first PLAY cycle, tone_en=1.
REQ-023 Latency: play sampled high in IDLE at edge n -> note_start high in the cycle after edge n+2.
REQ-024 PLAY with play=1: each beat pulse decrements counter; beat at counter=1 -> done_with_note pulse in the next cycle, rom_addr+1, next state GAP (macro on) or FETCH (macro off).
REQ-025 Beat pulses during FETCH, LOAD, or the cycle entering PLAY SHALL NOT be counted.
REQ-026 PLAY with play=0: pause; beats ignored, counter held, tone_en=0; on play=1, tone_en=1 again, no new note_start.
REQ-027 Back-to-back notes, macro off: note_start follows done_with_note by exactly 2 cycles, tone_en stays 1.
REQ-028 rom_addr at 2^ADDR_W-1 after note end SHALL wrap to 0 and continue.
REQ-029 END: hold until rewind; play ignored.
REQ-030 rewind in any state: next cycle rom_addr=0, state IDLE, counter=0, tone_en=0, note_pitch/note_duration=0, song_done=0, pulses suppressed.
REQ-031 rewind and beat in the same cycle: rewind wins, beat discarded.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 reset=0 SHALL immediately force state IDLE, rom_addr=0, note_pitch=0, note_duration=0, note_start=0, done_with_note=0, tone_en=0, song_done=0, counter=0.
REQ-034 Reset asserted mid-note SHALL abort the note with no done_with_note pulse.

Configuration
REQ-035 Macro NOTE_SCHED_GAP_EN defined: GAP state between notes, tone_en=0, exit to FETCH on the next beat pulse (articulation rest); play=0 in GAP holds GAP.
REQ-036 Macro undefined: GAP state absent, PLAY -> FETCH directly.

Structure
REQ-037 Package note_sched_pkg SHALL hold the state enum, DUR_W/PITCH_W defaults, END_MARKER=0 and entry field slice constants.
REQ-038 Sub-module beat_down_counter (load, dec, hold, count==1 flag) SHALL implement the beat counter.

Verification
REQ-039 ROM {3,P0},{0,-}; play=1 -> note_start 2 cycles after play, done_with_note after 3rd beat, then song_done=1, tone_en=0.
REQ-040 ROM {2,P0},{4,P1},{0,-}, macro off -> note_start(P1) exactly 2 cycles after first done_with_note; P1 lasts 4 beats.
REQ-041 Duration 5, play=0 after 2 beats for 3 beat periods -> tone_en=0 while paused, done_with_note after 3 further beats once resumed.
REQ-042 rewind coincident with beat mid-note -> rom_addr=0, IDLE, no done_with_note; play=1 restarts entry 0.
REQ-043 Macro on, ROM {1,P0},{1,P1} -> tone_en=0 for one beat between notes, note_start(P1) 2 cycles after the gap-ending beat.
REQ-044 reset=0 asserted mid-note asynchronously -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/note_scheduler_pkg.sv
// note_sched_pkg: shared types and constants for the note scheduler.
// Rev 1.0
`default_nettype none

package note_sched_pkg;

  localparam int ADDR_W_DEFAULT  = 10;
  localparam int DUR_W_DEFAULT   = 6;
  localparam int PITCH_W_DEFAULT = 24;

  // A song entry whose duration field equals this value terminates the song.
  localparam int END_MARKER = 0;

  // Song entries are packed {duration, pitch}, with pitch in the low bits.
  localparam int PITCH_LSB = 0;

  function automatic int dur_lsb(input int pitch_w);
    return PITCH_LSB + pitch_w;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4,
    END   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/note_scheduler_counter.sv
// beat_down_counter: loadable beat down-counter with a count==1 flag.
// Rev 1.0
`default_nettype none

module beat_down_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_one
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_one = (r_cnt == W'(1));

endmodule

`default_nettype wire

// File: rtl/note_scheduler.sv
// note_scheduler: walks a song ROM and sequences notes to tone/dynamics blocks.
// Macro NOTE_SCHED_GAP_EN inserts a one-beat silent GAP between notes. Rev 1.0
`default_nettype none

module note_scheduler
  import note_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DUR_W   = DUR_W_DEFAULT,
  parameter int PITCH_W = PITCH_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic                     rewind,
  input  logic                     beat,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DUR_W+PITCH_W-1:0] rom_data,
  output logic [PITCH_W-1:0]       note_pitch,
  output logic [DUR_W-1:0]         note_duration,
  output logic                     note_start,
  output logic                     done_with_note,
  output logic                     tone_en,
  output logic                     song_done
);

  localparam int DUR_LSB = dur_lsb(PITCH_W);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [PITCH_W-1:0]  r_pitch;
  logic [DUR_W-1:0]    r_dur;
  logic                r_start;
  logic                r_done;
  logic                r_tone;
  logic                r_song_done;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [PITCH_W-1:0]  w_pitch_nxt;
  logic [DUR_W-1:0]    w_dur_nxt;
  logic                w_start_nxt;
  logic                w_done_nxt;
  logic                w_tone_nxt;
  logic                w_song_done_nxt;
  logic                w_cnt_load;
  logic                w_cnt_dec;
  logic                w_cnt_one;
  logic                w_beat_counted;
  logic [DUR_W-1:0]    w_rom_dur;
  logic [PITCH_W-1:0]  w_rom_pitch;

  assign w_rom_dur   = rom_data[DUR_LSB +: DUR_W];
  assign w_rom_pitch = rom_data[PITCH_LSB +: PITCH_W];

  // The first PLAY cycle (note_start high) never consumes a beat.
  assign w_beat_counted = (r_state == PLAY) && play && beat && !r_start;

  beat_down_counter #(
    .W (DUR_W)
  ) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (rewind),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (w_rom_dur),
    .o_one      (w_cnt_one)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_pitch     <= '0;
      r_dur       <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_tone      <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_pitch     <= w_pitch_nxt;
      r_dur       <= w_dur_nxt;
      r_start     <= w_start_nxt;
      r_done      <= w_done_nxt;
      r_tone      <= w_tone_nxt;
      r_song_done <= w_song_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_pitch_nxt     = r_pitch;
    w_dur_nxt       = r_dur;
    w_start_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_tone_nxt      = r_tone;
    w_song_done_nxt = r_song_done;
    w_cnt_load      = 1'b0;
    w_cnt_dec       = 1'b0;

    if (rewind) begin
      w_state_nxt     = IDLE;
      w_addr_nxt      = '0;
      w_pitch_nxt     = '0;
      w_dur_nxt       = '0;
      w_tone_nxt      = 1'b0;
      w_song_done_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_tone_nxt = 1'b0;
          if (play) begin
            w_state_nxt = FETCH;
          end
        end
        FETCH: begin
          w_state_nxt = LOAD;
        end
        LOAD: begin
          if (w_rom_dur == DUR_W'(END_MARKER)) begin
            w_state_nxt     = END;
            w_song_done_nxt = 1'b1;
            w_tone_nxt      = 1'b0;
          end else begin
            w_state_nxt = PLAY;
            w_pitch_nxt = w_rom_pitch;
            w_dur_nxt   = w_rom_dur;
            w_cnt_load  = 1'b1;
            w_start_nxt = 1'b1;
            w_tone_nxt  = 1'b1;
          end
        end
        PLAY: begin
          w_tone_nxt = play;
          if (w_beat_counted) begin
            w_cnt_dec = 1'b1;
            if (w_cnt_one) begin
              w_done_nxt = 1'b1;
              w_addr_nxt = r_addr + ADDR_W'(1);
`ifdef NOTE_SCHED_GAP_EN
              w_state_nxt = GAP;
              w_tone_nxt  = 1'b0;
`else
              w_state_nxt = FETCH;
              w_tone_nxt  = 1'b1;
`endif
            end
          end
        end
`ifdef NOTE_SCHED_GAP_EN
        GAP: begin
          w_tone_nxt = 1'b0;
          if (play && beat) begin
            w_state_nxt = FETCH;
          end
        end
`endif
        END: begin
          w_tone_nxt      = 1'b0;
          w_song_done_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_tone_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign rom_addr       = r_addr;
  assign note_pitch     = r_pitch;
  assign note_duration  = r_dur;
  assign note_start     = r_start;
  assign done_with_note = r_done;
  assign tone_en        = r_tone;
  assign song_done      = r_song_done;

endmodule

`default_nettype wire

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed self-checking bench for note_scheduler.
// Rev 1.0
`default_nettype none

module tb_note_scheduler;

  localparam int ADDR_W  = 4;
  localparam int DUR_W   = 6;
  localparam int PITCH_W = 24;
  localparam int E_W     = DUR_W + PITCH_W;

  localparam logic [PITCH_W-1:0] P0 = 24'h123456;
  localparam logic [PITCH_W-1:0] P1 = 24'h0ABCDE;
  localparam logic [PITCH_W-1:0] P2 = 24'h00F00D;
  localparam logic [PITCH_W-1:0] P3 = 24'h3C3C3C;
  localparam logic [PITCH_W-1:0] P4 = 24'h777001;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               play = 1'b0;
  logic               rewind = 1'b0;
  logic               beat = 1'b0;
  logic [ADDR_W-1:0]  rom_addr;
  logic [E_W-1:0]     rom_data = '0;
  logic [PITCH_W-1:0] note_pitch;
  logic [DUR_W-1:0]   note_duration;
  logic               note_start;
  logic               done_with_note;
  logic               tone_en;
  logic               song_done;

  logic [E_W-1:0] rom_mem [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  note_scheduler #(
    .ADDR_W  (ADDR_W),
    .DUR_W   (DUR_W),
    .PITCH_W (PITCH_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .play           (play),
    .rewind         (rewind),
    .beat           (beat),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .note_pitch     (note_pitch),
    .note_duration  (note_duration),
    .note_start     (note_start),
    .done_with_note (done_with_note),
    .tone_en        (tone_en),
    .song_done      (song_done)
  );

  function automatic logic [E_W-1:0] entry(input int d, input logic [PITCH_W-1:0] p);
    return {DUR_W'(d), p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom_mem[i] = '0;
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
  endtask

  task automatic do_beat(output logic saw_done);
    beat = 1'b1;
    step();
    saw_done = done_with_note;
    beat = 1'b0;
    step();
    step();
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (note_start !== 1'b1 && n < 20);
  endtask

  task automatic test_reset();
    logic [ADDR_W+PITCH_W+DUR_W+5-1:0] all_out;
    step();
    step();
    all_out = {rom_addr, note_pitch, note_duration, note_start, done_with_note, tone_en, song_done, 1'b0};
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0", all_out);
    end
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({tone_en, song_done, note_start, rom_addr} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got %0h expected 0", {tone_en, song_done, note_start, rom_addr});
    end
  endtask

  task automatic test_single_note();
    int n;
    logic saw;
    clear_rom();
    rom_mem[0] = entry(3, P0);
    play = 1'b1;
    wait_start(n);
    checks++;
    if (n !== 3) begin failures++; $display("FAIL single_latency: got %0d expected 3", n); end
    checks++;
    if ({note_pitch, note_duration, tone_en} !== {P0, 6'd3, 1'b1}) begin
      failures++;
      $display("FAIL single_latch: got %0h/%0d/%0b expected %0h/3/1", note_pitch, note_duration, tone_en, P0);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      do_beat(saw);
      checks++;
      if (saw !== 1'b0) begin failures++; $display("FAIL single_early_done: beat %0d got %0b expected 0", k, saw); end
    end
    beat = 1'b1;
    step();
    beat = 1'b0;
    checks++;
    if ({done_with_note, rom_addr} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL single_done: got done=%0b addr=%0d expected done=1 addr=1", done_with_note, rom_addr);
    end
`ifdef NOTE_SCHED_GAP_EN
    step();
    beat = 1'b1;
    step();
    beat = 1'b0;
    step();
`else
    step();
    checks++;
    if (tone_en !== 1'b1) begin failures++; $display("FAIL single_tone_fetch: got %0b expected 1", tone_en); end
`endif
    step();
    checks++;
    if ({song_done, tone_en, note_start} !== 3'b100) begin
      failures++;
      $display("FAIL single_end: got %03b expected 100", {song_done, tone_en, note_start});
    end
    step();
    step();
    step();
    checks++;
    if ({song_done, note_start, rom_addr} !== {1'b1, 1'b0, 4'd1}) begin
      failures++;
      $display("FAIL end_hold: got %0h expected %0h", {song_done, note_start, rom_addr}, {1'b1, 1'b0, 4'd1});
    end
  endtask

`ifndef NOTE_SCHED_GAP_EN
  task automatic test_back_to_back();
    int n;
    logic saw;
    clear_rom();
    rom_mem[0] = entry(2, P0);
    rom_mem[1] = entry(4, P1);
    do_rewind();
    checks++;
    if ({rom_addr, song_done, tone_en, note_pitch, note_duration} !== '0) begin
      failures++;
      $display("FAIL rewind_from_end: got %0h expected 0", {rom_addr, song_done, tone_en, note_pitch, note_duration});
    end
    wait_start(n);
    step();
    do_beat(saw);
    beat = 1'b1;
    step();
    beat = 1'b0;
    checks++;
    if (done_with_note !== 1'b1) begin failures++; $display("FAIL b2b_done: got %0b expected 1", done_with_note); end
    wait_start(n);
    checks++;
    if (n !== 2) begin failures++; $display("FAIL b2b_gap_cycles: got %0d expected 2", n); end
    checks++;
    if ({note_pitch, note_duration, tone_en} !== {P1, 6'd4, 1'b1}) begin
      failures++;
      $display("FAIL b2b_second: got %0h/%0d/%0b expected %0h/4/1", note_pitch, note_duration, tone_en, P1);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      do_beat(saw);
      checks++;
      if (saw !== (k == 3)) begin failures++; $display("FAIL b2b_len: beat %0d got %0b expected %0b", k, saw, k == 3); end
    end
  endtask
`endif

  task automatic test_pause();
    int n;
    logic saw;
    clear_rom();
    rom_mem[0] = entry(5, P2);
    do_rewind();
    wait_start(n);
    checks++;
    if (n !== 3 || note_pitch !== P2) begin
      failures++;
      $display("FAIL pause_start: got n=%0d pitch=%0h expected n=3 pitch=%0h", n, note_pitch, P2);
    end
    step();
    do_beat(saw);
    do_beat(saw);
    play = 1'b0;
    step();
    checks++;
    if (tone_en !== 1'b0) begin failures++; $display("FAIL pause_tone: got %0b expected 0", tone_en); end
    for (int k = 0; k < 3; k++) begin
      do_beat(saw);
      checks++;
      if ({saw, tone_en} !== 2'b00) begin failures++; $display("FAIL paused_beat: beat %0d got %02b expected 00", k, {saw, tone_en}); end
    end
    play = 1'b1;
    step();
    checks++;
    if ({tone_en, note_start} !== 2'b10) begin failures++; $display("FAIL resume: got %02b expected 10", {tone_en, note_start}); end
    for (int k = 0; k < 3; k++) begin
      do_beat(saw);
      checks++;
      if (saw !== (k == 2)) begin failures++; $display("FAIL resume_len: beat %0d got %0b expected %0b", k, saw, k == 2); end
    end
  endtask

  task automatic test_rewind_beat();
    int n;
    logic saw;
    clear_rom();
    rom_mem[0] = entry(4, P3);
    do_rewind();
    wait_start(n);
    step();
    do_beat(saw);
    rewind = 1'b1;
    beat = 1'b1;
    step();
    rewind = 1'b0;
    beat = 1'b0;
    checks++;
    if ({done_with_note, rom_addr, tone_en, note_pitch, note_duration, song_done, note_start} !== '0) begin
      failures++;
      $display("FAIL rewind_beat: got %0h expected 0", {done_with_note, rom_addr, tone_en, note_pitch, note_duration, song_done, note_start});
    end
    wait_start(n);
    checks++;
    if (n !== 3 || note_pitch !== P3 || note_duration !== 6'd4) begin
      failures++;
      $display("FAIL rewind_restart: got n=%0d pitch=%0h dur=%0d expected n=3 pitch=%0h dur=4", n, note_pitch, note_duration, P3);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      do_beat(saw);
      checks++;
      if (saw !== (k == 3)) begin failures++; $display("FAIL rewind_len: beat %0d got %0b expected %0b", k, saw, k == 3); end
    end
  endtask

  task automatic test_wrap();
    int n;
    for (int i = 0; i < 16; i++) rom_mem[i] = entry(1, PITCH_W'(24'h100 + i));
    do_rewind();
    for (int i = 0; i < 16; i++) begin
      wait_start(n);
      checks++;
      if (n !== ((i == 0) ? 3 : 2) || note_pitch !== PITCH_W'(24'h100 + i)) begin
        failures++;
        $display("FAIL wrap_note%0d: got n=%0d pitch=%0h expected n=%0d pitch=%0h", i, n, note_pitch, (i == 0) ? 3 : 2, 24'h100 + i);
      end
      step();
      beat = 1'b1;
      step();
      beat = 1'b0;
      checks++;
      if ({done_with_note, rom_addr} !== {1'b1, 4'((i + 1) % 16)}) begin
        failures++;
        $display("FAIL wrap_done%0d: got done=%0b addr=%0d expected done=1 addr=%0d", i, done_with_note, rom_addr, (i + 1) % 16);
      end
`ifdef NOTE_SCHED_GAP_EN
      step();
      beat = 1'b1;
      step();
      beat = 1'b0;
`endif
    end
    wait_start(n);
    checks++;
    if (n !== 2 || note_pitch !== 24'h100) begin
      failures++;
      $display("FAIL wrap_continue: got n=%0d pitch=%0h expected n=2 pitch=100", n, note_pitch);
    end
  endtask

`ifdef NOTE_SCHED_GAP_EN
  task automatic test_gap();
    int n;
    clear_rom();
    rom_mem[0] = entry(1, P0);
    rom_mem[1] = entry(1, P1);
    do_rewind();
    wait_start(n);
    step();
    beat = 1'b1;
    step();
    beat = 1'b0;
    checks++;
    if ({done_with_note, tone_en} !== 2'b10) begin failures++; $display("FAIL gap_enter: got %02b expected 10", {done_with_note, tone_en}); end
    step();
    step();
    checks++;
    if ({tone_en, note_start} !== 2'b00) begin failures++; $display("FAIL gap_hold: got %02b expected 00", {tone_en, note_start}); end
    beat = 1'b1;
    step();
    beat = 1'b0;
    wait_start(n);
    checks++;
    if (n !== 2 || note_pitch !== P1 || tone_en !== 1'b1) begin
      failures++;
      $display("FAIL gap_exit: got n=%0d pitch=%0h tone=%0b expected n=2 pitch=%0h tone=1", n, note_pitch, tone_en, P1);
    end
  endtask
`endif

  task automatic test_async_reset();
    int n;
    logic saw;
    logic seen_done;
    clear_rom();
    rom_mem[0] = entry(6, P4);
    do_rewind();
    wait_start(n);
    step();
    do_beat(saw);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({rom_addr, note_pitch, note_duration, note_start, done_with_note, tone_en, song_done} !== '0) begin
      failures++;
      $display("FAIL async_reset: got %0h expected 0", {rom_addr, note_pitch, note_duration, note_start, done_with_note, tone_en, song_done});
    end
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat = 1'b1;
      step();
      seen_done = seen_done | done_with_note;
    end
    beat = 1'b0;
    reset = 1'b1;
    step();
    seen_done = seen_done | done_with_note;
    checks++;
    if ({seen_done, tone_en, note_start} !== 3'b000) begin
      failures++;
      $display("FAIL reset_abort: got %03b expected 000", {seen_done, tone_en, note_start});
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_single_note();
`ifndef NOTE_SCHED_GAP_EN
    test_back_to_back();
`endif
    test_pause();
    test_rewind_beat();
    test_wrap();
`ifdef NOTE_SCHED_GAP_EN
    test_gap();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
